uart_wb: RTL and testbench
==========================

# uart_wb

Wishbone slave UART on the core's data bus, downstream of the CPU's data Wishbone master. It converts single-word register reads and writes into 8N1 serial transmit and receive traffic. Its level interrupt drives the core's `int_i` input.

## Interface
- `DEFAULT_DIV`, 16'd433: reset value of the baud divisor. One bit period is DIV+1 clocks; 433 gives 115200 baud at 50 MHz.
- `RX_FIFO_DEPTH`, 8: RX FIFO entries, power of two. Used only when `UART_RX_FIFO_EN` is defined.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous and active-low.
- `wb_adr_i` in 32: byte address. Only [3:2] are decoded: 0 DATA, 1 STATUS, 2 CTRL, 3 DIV.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data, registered, valid while `wb_ack_o`=1.
- `wb_we_i` in 1: write enable.
- `wb_sel_i` in 4: byte selects. An access with sel=0 is acked with no side effect.
- `wb_stb_i` in 1: strobe.
- `wb_cyc_i` in 1: cycle.
- `wb_ack_o` out 1: one-cycle acknowledge.
- `uart_rx_i` in 1: serial input, asynchronous.
- `uart_tx_o` out 1: serial output, idle high.
- `int_o` out 1: registered level interrupt.

## Operation
- Registers:
  - DATA write: dat_i[7:0] starts a TX frame if TX is idle, else the write is dropped. DATA read: returns {24'b0, rx byte} and pops one entry. Reading while empty returns 0 with no pop.
  - STATUS (read-only): bit0 rx_valid, bit1 tx_busy, bit2 rx_overrun, bit3 frame_err. Bits 2 and 3 are sticky and clear on STATUS read.
  - CTRL: bit0 rx_int_en, bit1 tx_int_en. Reset 0.
  - DIV: [15:0], reset `DEFAULT_DIV`. Writing 0 is legal and gives a 1-clock bit period.
- TX FSM, states IDLE→START→DATA(8 bits, LSB first)→STOP→IDLE. Each state lasts DIV+1 clocks, counted by a 16-bit down counter and a 3-bit bit index.
- RX path:
  - Input passes through a 2-flop synchroniser.
  - IDLE leaves on a sampled 1→0 edge into START.
  - START samples at count (DIV+1)/2. If the line is high there, it was a glitch: return to IDLE.
  - DATA takes 8 samples, one every DIV+1 clocks, then STOP takes one sample.
  - Stop sample = 0: set frame_err, discard the byte.
  - Buffer full when a byte completes: set rx_overrun, drop the new byte, keep the old data.
- `int_o` = (rx_int_en & rx_valid) | (tx_int_en & ~tx_busy), registered.
- A DIV write during a frame takes effect at the next bit boundary of each FSM.

## Timing
- Bus handshake:
  - cyc&stb&~ack in cycle N gives ack=1 in cycle N+1 for exactly one cycle. Read data is valid in N+1.
  - Side effects (TX start, pop, sticky clear, register write) commit in the ack cycle only. Holding stb across ack does not double-commit.
  - Back-to-back accesses: ack at most every second cycle.
- TX timing:
  - A DATA write acked in cycle N drives `uart_tx_o` low in N+1. tx_busy reads 1 from N+1.
  - Frame length is 10·(DIV+1) clocks. tx_busy falls in the same cycle `uart_tx_o` leaves the stop bit.
- RX latency: rx_valid rises 2 sync cycles after the mid-stop sample.
- Simultaneous events:
  - Pop and push in the same cycle: both occur. The occupancy count is unchanged, or in single-register mode the new byte replaces the old.
  - STATUS read in the same cycle a sticky bit sets: the set wins.
- Reset (may assert mid-frame):
  - Both FSMs go to IDLE, the buffer empties, flags clear.
  - Output reset values: `uart_tx_o`=1, `wb_ack_o`=0, `wb_dat_o`=0, `int_o`=0.
  - CTRL=0, DIV=`DEFAULT_DIV`.

## Configuration
- `UART_RX_FIFO_EN` defined:
  - RX buffer is a `RX_FIFO_DEPTH`-entry FIFO with wrap-around pointers and a count one bit wider than the pointers.
  - rx_valid = count≠0. Overrun sets when count=`RX_FIFO_DEPTH` and a byte completes.
- `UART_RX_FIFO_EN` undefined: single holding register plus a valid bit. Overrun sets when valid=1 and a byte completes without a same-cycle pop.

## Structure
- The shared defines header holds the register offsets (`UART_REG_DATA`/`STATUS`/`CTRL`/`DIV`), STATUS/CTRL bit positions and the FSM state encodings.
- One sub-module, `uart_rx`: synchroniser, RX FSM, framing. It outputs a byte plus a one-cycle valid and frame-error pulse.
- The top level holds the Wishbone decode, registers, TX FSM, buffer and interrupt.

## Test plan
- Reset, then read DIV, STATUS and CTRL → 433, 0, 0. `uart_tx_o`=1 throughout.
- DIV=3, write DATA 0xA5 → `uart_tx_o` bits 0,1,0,1,0,0,1,0,1,1, each 4 clocks (40 total). tx_busy clears at the end of the stop bit. A second write during the frame is dropped.
- DIV=3, drive serial 0x3C on rx, then read DATA → 0x3C. STATUS bit0 then reads 0.
- Drive a 1-clock low glitch on rx → no byte, no flags. Drive a frame with stop bit 0 → STATUS=0x8, then 0 on the next read.
- Without the macro, receive 2 bytes without reading → DATA=first byte, STATUS bit2=1. With the macro, receive 9 bytes → 8 bytes pop in order, then overrun=1.
- CTRL=1, receive a byte → `int_o`=1 until the DATA pop. Assert `rst` mid-TX → `uart_tx_o`=1 immediately and the buffer is empty.

Source files
------------

// File: rtl/uart_wb_pkg.sv
// Shared register map, status/control bit positions and FSM encodings for uart_wb.
package uart_wb_pkg;

    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_CTRL   = 2'd2;
    localparam logic [1:0] UART_REG_DIV    = 2'd3;

    localparam int ST_RX_VALID   = 0;
    localparam int ST_TX_BUSY    = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_FRAME_ERR  = 3;

    localparam int CTRL_RX_INT_EN = 0;
    localparam int CTRL_TX_INT_EN = 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // (div+1)/2 without overflowing at div=16'hFFFF
    function automatic logic [15:0] half_period(input logic [15:0] div);
        logic [16:0] p;
        p = {1'b0, div} + 17'd1;
        return p[16:1];
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchroniser, start-bit glitch filter, mid-bit sampling.
// state    | meaning
// RX_IDLE  | line idle, waiting for a synchronised 1->0 edge
// RX_START | counting to mid start bit; high there means glitch
// RX_DATA  | one sample per bit period, LSB first, 8 bits
// RX_STOP  | single mid-stop sample: 1 gives rx_done, 0 gives rx_ferr
module uart_rx
    import uart_wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] div,
    input  logic        rx_line,
    output logic [7:0]  rx_byte,
    output logic        rx_done,
    output logic        rx_ferr
);

    logic sync1, sync2, sync_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= rx_line;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    rx_state_t   state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [2:0]  bit_idx, bit_nx;
    logic [7:0]  shreg, shreg_nx;
    logic        done_nx, ferr_nx;
    logic [15:0] half;

    assign half    = half_period(div);
    assign rx_byte = shreg;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bit_nx   = bit_idx;
        shreg_nx = shreg;
        done_nx  = 1'b0;
        ferr_nx  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (sync_prev && !sync2) begin
                    state_nx = RX_START;
                    // edge cycle already counts as the first start-bit clock
                    cnt_nx   = (half == 16'd0) ? 16'd0 : half - 16'd1;
                end
            end
            RX_START: begin
                if (cnt == 16'd0) begin
                    if (sync2) begin
                        state_nx = RX_IDLE;
                    end else begin
                        state_nx = RX_DATA;
                        cnt_nx   = div;
                        bit_nx   = 3'd0;
                    end
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt == 16'd0) begin
                    shreg_nx = {sync2, shreg[7:1]};
                    cnt_nx   = div;
                    bit_nx   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nx = RX_STOP;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt == 16'd0) begin
                    state_nx = RX_IDLE;
                    if (sync2) done_nx = 1'b1;
                    else       ferr_nx = 1'b1;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            default: state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RX_IDLE;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            rx_done <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_nx;
            shreg   <= shreg_nx;
            rx_done <= done_nx;
            rx_ferr <= ferr_nx;
        end
    end

endmodule

// File: rtl/uart_wb.sv
// Wishbone UART: register decode, TX FSM, RX buffer and level interrupt.
// Define UART_RX_FIFO_EN for an RX_FIFO_DEPTH-entry RX FIFO instead of one holding register.
// state    | meaning
// TX_IDLE  | line high, DATA write starts a frame
// TX_START | start bit (low)
// TX_DATA  | 8 data bits, LSB first, tx_bit selects the bit
// TX_STOP  | stop bit (high); tx_busy drops as it ends
module uart_wb
    import uart_wb_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV   = 16'd433,
    parameter int          RX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic        int_o
);

    logic        req, commit, wr_commit, rd_commit;
    logic        a_we, a_valid;
    logic [1:0]  a_reg, a_flags;
    logic [3:0]  a_sel;
    logic [15:0] a_dat;
    logic [1:0]  ctrl;
    logic [15:0] div;
    logic        rx_valid, tx_busy, pop;
    logic        overrun_flag, frame_flag, overrun_set, st_clr;
    logic [7:0]  head, rx_byte;
    logic        rx_done, rx_ferr;
    logic [31:0] rd_data;
    logic        unused;

    assign unused = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16]};

    // Request attributes are captured so the ack cycle commits even if the master drops stb.
    assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign commit    = wb_ack_o & (|a_sel);
    assign wr_commit = commit & a_we;
    assign rd_commit = commit & ~a_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
            a_we     <= 1'b0;
            a_reg    <= 2'd0;
            a_sel    <= 4'd0;
            a_dat    <= 16'd0;
            a_valid  <= 1'b0;
            a_flags  <= 2'd0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= (req && !wb_we_i) ? rd_data : 32'd0;
            if (req) begin
                a_we    <= wb_we_i;
                a_reg   <= wb_adr_i[3:2];
                a_sel   <= wb_sel_i;
                a_dat   <= wb_dat_i[15:0];
                a_valid <= rx_valid;
                a_flags <= {frame_flag, overrun_flag};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl <= 2'd0;
            div  <= DEFAULT_DIV;
        end else if (wr_commit) begin
            if (a_reg == UART_REG_CTRL && a_sel[0]) ctrl <= a_dat[1:0];
            if (a_reg == UART_REG_DIV) begin
                if (a_sel[0]) div[7:0]  <= a_dat[7:0];
                if (a_sel[1]) div[15:8] <= a_dat[15:8];
            end
        end
    end

    tx_state_t   tx_state, tx_state_nx;
    logic [15:0] tx_cnt, tx_cnt_nx;
    logic [2:0]  tx_bit, tx_bit_nx;
    logic [7:0]  tx_byte, tx_byte_nx;
    logic        tx_line_nx, tx_start;

    assign tx_busy  = (tx_state != TX_IDLE);
    assign tx_start = wr_commit && (a_reg == UART_REG_DATA) && a_sel[0];

    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_bit_nx   = tx_bit;
        tx_byte_nx  = tx_byte;
        tx_line_nx  = uart_tx_o;
        case (tx_state)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_state_nx = TX_START;
                    tx_cnt_nx   = div;
                    tx_byte_nx  = a_dat[7:0];
                    tx_line_nx  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == 16'd0) begin
                    tx_state_nx = TX_DATA;
                    tx_cnt_nx   = div;
                    tx_bit_nx   = 3'd0;
                    tx_line_nx  = tx_byte[0];
                end else begin
                    tx_cnt_nx = tx_cnt - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == 16'd0) begin
                    tx_cnt_nx = div;
                    if (tx_bit == 3'd7) begin
                        tx_state_nx = TX_STOP;
                        tx_line_nx  = 1'b1;
                    end else begin
                        tx_bit_nx  = tx_bit + 3'd1;
                        tx_line_nx = tx_byte[tx_bit + 3'd1];
                    end
                end else begin
                    tx_cnt_nx = tx_cnt - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == 16'd0) begin
                    tx_state_nx = TX_IDLE;
                    tx_line_nx  = 1'b1;
                end else begin
                    tx_cnt_nx = tx_cnt - 16'd1;
                end
            end
            default: begin
                tx_state_nx = TX_IDLE;
                tx_line_nx  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= 16'd0;
            tx_bit    <= 3'd0;
            tx_byte   <= 8'd0;
            uart_tx_o <= 1'b1;
        end else begin
            tx_state  <= tx_state_nx;
            tx_cnt    <= tx_cnt_nx;
            tx_bit    <= tx_bit_nx;
            tx_byte   <= tx_byte_nx;
            uart_tx_o <= tx_line_nx;
        end
    end

    uart_rx u_rx (
        .clk     (clk),
        .rst     (rst),
        .div     (div),
        .rx_line (uart_rx_i),
        .rx_byte (rx_byte),
        .rx_done (rx_done),
        .rx_ferr (rx_ferr)
    );

    // Pop only if the read actually saw a valid byte, so a late push is never lost.
    assign pop = rd_commit && (a_reg == UART_REG_DATA) && a_valid;

`ifdef UART_RX_FIFO_EN
    localparam int PW = $clog2(RX_FIFO_DEPTH);
    logic [7:0]    mem [RX_FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   count;
    logic          full, push_ok;

    assign rx_valid    = (count != '0);
    assign full        = (count == (PW+1)'(RX_FIFO_DEPTH));
    assign push_ok     = rx_done & ~full;
    assign overrun_set = rx_done & full;
    assign head        = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= rx_byte;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PW'(1);
            if (pop)     rptr <= rptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end
`else
    localparam int unused_depth = RX_FIFO_DEPTH;
    logic [7:0] hold;
    logic       hold_valid;

    assign rx_valid    = hold_valid;
    assign head        = hold;
    assign overrun_set = rx_done & hold_valid & ~pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold       <= 8'd0;
            hold_valid <= 1'b0;
        end else if (rx_done && !(hold_valid && !pop)) begin
            hold       <= rx_byte;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    assign st_clr = rd_commit && (a_reg == UART_REG_STATUS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_flag <= 1'b0;
            frame_flag   <= 1'b0;
            int_o        <= 1'b0;
        end else begin
            overrun_flag <= overrun_set | (overrun_flag & ~(st_clr & a_flags[0]));
            frame_flag   <= rx_ferr     | (frame_flag   & ~(st_clr & a_flags[1]));
            int_o        <= (ctrl[CTRL_RX_INT_EN] & rx_valid) | (ctrl[CTRL_TX_INT_EN] & ~tx_busy);
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (wb_adr_i[3:2])
            UART_REG_DATA:   rd_data = rx_valid ? {24'd0, head} : 32'd0;
            UART_REG_STATUS: begin
                rd_data[ST_RX_VALID]   = rx_valid;
                rd_data[ST_TX_BUSY]    = tx_busy;
                rd_data[ST_RX_OVERRUN] = overrun_flag;
                rd_data[ST_FRAME_ERR]  = frame_flag;
            end
            UART_REG_CTRL:   rd_data = {30'd0, ctrl};
            default:         rd_data = {16'd0, div};
        endcase
    end

endmodule

// File: tb/tb_uart_wb.sv
// Directed bench for uart_wb: register reset values, TX framing, RX, glitch, frame error, overrun, interrupt, reset.
module tb_uart_wb;

    localparam int BIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] wb_adr_i = 32'd0;
    logic [31:0] wb_dat_i = 32'd0;
    logic [31:0] wb_dat_o;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = 4'd0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic        uart_rx_i = 1'b1;
    logic        uart_tx_o;
    logic        int_o;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    uart_wb dut (
        .clk       (clk),
        .rst       (rst),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_we_i   (wb_we_i),
        .wb_sel_i  (wb_sel_i),
        .wb_stb_i  (wb_stb_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_ack_o  (wb_ack_o),
        .uart_rx_i (uart_rx_i),
        .uart_tx_o (uart_tx_o),
        .int_o     (int_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] reg_idx, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        int n;
        @(negedge clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = {28'd0, reg_idx, 2'b00};
        wb_dat_i = wdat;
        wb_sel_i = 4'hF;
        n = 0;
        rdat = 32'd0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb_ack_o && n < 8);
        if (!wb_ack_o) check("ack_timeout", 32'(wb_ack_o), 32'd1);
        else           rdat = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'd0;
    endtask

    task automatic wr(input logic [1:0] reg_idx, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_xfer(1'b1, reg_idx, wdat, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [1:0] reg_idx, input logic [31:0] exp);
        logic [31:0] v;
        wb_xfer(1'b0, reg_idx, 32'd0, v);
        check(tag, v, exp);
    endtask

    // One 8N1 frame at DIV=3, followed by one idle bit period
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx_i = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx_i = stop;
        repeat (BIT) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    initial begin : main
        logic [7:0] txb;
        logic       exp_bit;
        int         a0;

        tick(3);
        check("rst_tx", 32'(uart_tx_o), 32'd1);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_int", 32'(int_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick(2);

        rd_check("div_reset", 2'd3, 32'd433);
        rd_check("status_reset", 2'd1, 32'd0);
        rd_check("ctrl_reset", 2'd2, 32'd0);
        check("tx_idle_after_reads", 32'(uart_tx_o), 32'd1);

        wr(2'd3, 32'd3);
        rd_check("div_write", 2'd3, 32'd3);

        // TX waveform for 0xA5: start, LSB-first data, stop; 4 clocks each
        txb = 8'hA5;
        wr(2'd0, 32'h0000_00A5);
        for (int i = 0; i < 10 * BIT; i++) begin
            tick(1);
            if (i / BIT == 0)      exp_bit = 1'b0;
            else if (i / BIT == 9) exp_bit = 1'b1;
            else                   exp_bit = txb[i / BIT - 1];
            check($sformatf("tx_bit_clk%0d", i), 32'(uart_tx_o), 32'(exp_bit));
        end
        tick(1);
        check("tx_after_frame", 32'(uart_tx_o), 32'd1);
        rd_check("status_tx_done", 2'd1, 32'd0);

        // Busy during frame; a second DATA write mid-frame must be dropped
        wr(2'd0, 32'h0000_005A);
        a0 = cyc_cnt;
        tick(2);
        rd_check("status_tx_busy", 2'd1, 32'h2);
        wr(2'd0, 32'h0000_00FF);
        while (cyc_cnt < a0 + 10 * BIT + 1) tick(1);
        check("tx_idle_at_frame_end", 32'(uart_tx_o), 32'd1);
        rd_check("status_second_write_dropped", 2'd1, 32'd0);

        // RX byte
        send_byte(8'h3C, 1'b1);
        tick(2);
        rd_check("status_rx_valid", 2'd1, 32'h1);
        rd_check("rx_data_3c", 2'd0, 32'h3C);
        rd_check("status_after_pop", 2'd1, 32'd0);
        rd_check("rx_empty_read", 2'd0, 32'd0);

        // One-clock low glitch
        @(negedge clk);
        uart_rx_i = 1'b0;
        @(negedge clk);
        uart_rx_i = 1'b1;
        tick(20);
        rd_check("status_glitch", 2'd1, 32'd0);
        rd_check("data_glitch", 2'd0, 32'd0);

        // Stop bit low: frame error, byte discarded, flag clears on read
        send_byte(8'h55, 1'b0);
        tick(2);
        rd_check("status_frame_err", 2'd1, 32'h8);
        rd_check("status_frame_err_cleared", 2'd1, 32'd0);
        rd_check("data_after_frame_err", 2'd0, 32'd0);

`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
        tick(2);
        rd_check("status_fifo_overrun", 2'd1, 32'h5);
        for (int i = 1; i <= 8; i++) rd_check($sformatf("fifo_pop%0d", i), 2'd0, 32'(i));
        rd_check("status_fifo_drained", 2'd1, 32'd0);
`else
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(2);
        rd_check("status_overrun", 2'd1, 32'h5);
        rd_check("data_keeps_first", 2'd0, 32'h11);
        rd_check("status_overrun_cleared", 2'd1, 32'd0);
`endif

        // Interrupt sources
        wr(2'd2, 32'h1);
        tick(2);
        check("int_rx_en_empty", 32'(int_o), 32'd0);
        send_byte(8'h96, 1'b1);
        tick(2);
        check("int_rx_pending", 32'(int_o), 32'd1);
        rd_check("data_96", 2'd0, 32'h96);
        tick(2);
        check("int_after_pop", 32'(int_o), 32'd0);
        wr(2'd2, 32'h2);
        tick(2);
        check("int_tx_idle", 32'(int_o), 32'd1);
        wr(2'd2, 32'h0);
        tick(2);
        check("int_disabled", 32'(int_o), 32'd0);

        // Reset mid-frame with a byte waiting in the buffer
        send_byte(8'h77, 1'b1);
        wr(2'd2, 32'h1);
        wr(2'd0, 32'h0000_0033);
        tick(2);
        check("tx_start_before_reset", 32'(uart_tx_o), 32'd0);
        check("int_before_reset", 32'(int_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("tx_in_reset", 32'(uart_tx_o), 32'd1);
        check("int_in_reset", 32'(int_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        check("tx_after_reset", 32'(uart_tx_o), 32'd1);
        rd_check("status_after_reset", 2'd1, 32'd0);
        rd_check("div_after_reset", 2'd3, 32'd433);
        rd_check("ctrl_after_reset", 2'd2, 32'd0);
        rd_check("data_after_reset", 2'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
